mips_fetch_unit: RTL

Parametrised instruction-fetch front end for the MIPS core.
- Replaces the externally driven ReadAddr with an internal program counter that addresses the byte-addressed IMEM.
- Buffers fetched {pc, instruction} pairs in a prefetch FIFO with a valid/ready handshake to decode.
- Redirects the PC on taken branches and jumps, using the Branch/Zero/SEImm/JumpValue signals from the execute stage.

---
 rtl/mips_fetch_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch front end: internal PC, prefetch FIFO toward decode, execute-stage redirects.
// Define MIPS_FETCH_STATS_EN to add the saturating stat_fetched / stat_flushes counters.
`default_nettype none

module mips_fetch_unit #(
    parameter int          ADDR_W   = 8,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [31:0]                imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    input  logic                       redir_branch,
    input  logic                       redir_zero,
    input  logic                       redir_jump,
    input  logic [31:0]                redir_pc,
    input  logic [31:0]                redir_seimm,
    input  logic [25:0]                redir_jval,
`ifdef MIPS_FETCH_STATS_EN
    output logic [15:0]                stat_fetched,
    output logic [15:0]                stat_flushes,
`endif
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      pc;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      mem_instr [DEPTH];
    logic [31:0]      mem_pc    [DEPTH];

    logic               full;
    logic               taken;
    logic               push;
    logic               pop;
    logic [31:0]        pc4;
    logic signed [31:0] seimm_s;
    logic [31:0]        jump_target;
    logic [31:0]        branch_target;
    logic [31:0]        target;

    assign imem_addr  = pc[ADDR_W-1:0];
    assign fifo_count = count;
    assign full       = (count == CNT_W'(DEPTH));
    assign out_valid  = (count != '0);

    assign taken = redir_jump | (redir_branch & redir_zero);
    assign pop   = out_valid & out_ready & ~taken;
    assign push  = ~taken & (~full | pop);

    // Jump wins over branch; branch offset is a signed word count.
    assign pc4           = redir_pc + 32'd4;
    assign seimm_s       = signed'(redir_seimm);
    assign jump_target   = {pc4[31:28], redir_jval, 2'b00};
    assign branch_target = pc4 + unsigned'(seimm_s <<< 2);
    assign target        = redir_jump ? jump_target : branch_target;

    assign out_instr = out_valid ? mem_instr[rd_ptr] : 32'd0;
    assign out_pc    = out_valid ? mem_pc[rd_ptr]    : 32'd0;

    // Control state: PC, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (taken) begin
            pc     <= target;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries data only; emptiness is tracked by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]    <= pc;
        end
    end

`ifdef MIPS_FETCH_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched <= '0;
            stat_flushes <= '0;
        end else begin
            if (push)
                stat_fetched <= sat_inc(stat_fetched);
            if (taken)
                stat_flushes <= sat_inc(stat_flushes);
        end
    end
`endif

endmodule

`default_nettype wire
